seq_alu: RTL

Multi-cycle ALU directly upstream of the accumulator. It latches operand A from the accumulator output and operand B from the register/ROM data path. It computes one of eight operations and presents the result with a one-cycle write-enable pulse that drives the accumulator's `we`. Single-cycle ops complete in 1 cycle; MUL and DIV iterate bit-serially.

---
 rtl/seq_alu_pkg.sv | 26 ++
 rtl/seq_alu_if.sv | 29 ++
 rtl/seq_alu_muldiv.sv | 108 ++++++++++
 rtl/seq_alu.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/seq_alu_pkg.sv
// Shared opcodes and FSM state encoding for the sequential ALU.
package alu_pkg;

  localparam int unsigned OP_WIDTH = 3;

  localparam logic [OP_WIDTH-1:0] OP_ADD   = 3'd0;
  localparam logic [OP_WIDTH-1:0] OP_SUB   = 3'd1;
  localparam logic [OP_WIDTH-1:0] OP_AND   = 3'd2;
  localparam logic [OP_WIDTH-1:0] OP_OR    = 3'd3;
  localparam logic [OP_WIDTH-1:0] OP_XOR   = 3'd4;
  localparam logic [OP_WIDTH-1:0] OP_PASSB = 3'd5;
  localparam logic [OP_WIDTH-1:0] OP_MUL   = 3'd6;
  localparam logic [OP_WIDTH-1:0] OP_DIV   = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_FIN  = 2'd2
  } state_e;

  // MUL and DIV are the only opcodes that go through the iterative datapath
  function automatic logic is_multi_cycle(input logic [OP_WIDTH-1:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Request/result bundle between the sequencer and the ALU.
interface seq_alu_if
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) ();

  logic                  start;
  logic [OP_WIDTH-1:0]   op;
  logic [DATA_WIDTH-1:0] operand_a;
  logic [DATA_WIDTH-1:0] operand_b;
  logic [DATA_WIDTH-1:0] result;
  logic                  acc_we;
  logic                  done;
  logic                  busy;
  logic                  flag_z;
  logic                  flag_c;

  modport master (
    output start, op, operand_a, operand_b,
    input  result, acc_we, done, busy, flag_z, flag_c
  );

  modport slave (
    input  start, op, operand_a, operand_b,
    output result, acc_we, done, busy, flag_z, flag_c
  );

endinterface

// File: rtl/seq_alu_muldiv.sv
// Bit-serial shift-add multiplier / restoring divider, one step per cycle.
// hi/lo form a 2*DATA_WIDTH working register: product for MUL,
// remainder:quotient for DIV.
module seq_muldiv #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  is_div,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  step_done,
  output logic [DATA_WIDTH-1:0] res_lo,
  output logic [DATA_WIDTH-1:0] res_hi,
  output logic                  div_zero
);

  localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);

  logic [DATA_WIDTH-1:0] hi_q, hi_d;
  logic [DATA_WIDTH-1:0] lo_q, lo_d;
  logic [DATA_WIDTH-1:0] opnd_q, opnd_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  run_q, run_d;
  logic                  is_div_q, is_div_d;
  logic                  step_done_q, step_done_d;
  logic                  div_zero_q, div_zero_d;

  logic [DATA_WIDTH:0]   shifted;
  logic [DATA_WIDTH:0]   trial;
  logic [DATA_WIDTH:0]   sum;

  // Working registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q        <= '0;
      lo_q        <= '0;
      opnd_q      <= '0;
      cnt_q       <= '0;
      run_q       <= 1'b0;
      is_div_q    <= 1'b0;
      step_done_q <= 1'b0;
      div_zero_q  <= 1'b0;
    end else begin
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      opnd_q      <= opnd_d;
      cnt_q       <= cnt_d;
      run_q       <= run_d;
      is_div_q    <= is_div_d;
      step_done_q <= step_done_d;
      div_zero_q  <= div_zero_d;
    end
  end

  // Load on request, then one multiply or divide step per cycle
  always_comb begin
    hi_d        = hi_q;
    lo_d        = lo_q;
    opnd_d      = opnd_q;
    cnt_d       = cnt_q;
    run_d       = run_q;
    is_div_d    = is_div_q;
    step_done_d = 1'b0;
    div_zero_d  = div_zero_q;

    shifted = {hi_q, lo_q[DATA_WIDTH-1]};
    trial   = shifted - {1'b0, opnd_q};
    sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);

    if (load) begin
      hi_d       = '0;
      lo_d       = is_div ? a : b;
      opnd_d     = is_div ? b : a;
      is_div_d   = is_div;
      cnt_d      = '0;
      run_d      = 1'b1;
      div_zero_d = (b == '0);
    end else if (run_q) begin
      if (is_div_q) begin
        // Restoring step: keep the subtraction only if it did not go negative
        if (!trial[DATA_WIDTH]) begin
          hi_d = trial[DATA_WIDTH-1:0];
          lo_d = {lo_q[DATA_WIDTH-2:0], 1'b1};
        end else begin
          hi_d = shifted[DATA_WIDTH-1:0];
          lo_d = {lo_q[DATA_WIDTH-2:0], 1'b0};
        end
      end else begin
        // Shift-add step: add multiplicand into the top half, shift right
        hi_d = sum[DATA_WIDTH:1];
        lo_d = {sum[0], lo_q[DATA_WIDTH-1:1]};
      end
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
        run_d       = 1'b0;
        step_done_d = 1'b1;
      end
    end
  end

  assign step_done = step_done_q;
  assign res_lo    = lo_q;
  assign res_hi    = hi_q;
  assign div_zero  = div_zero_q;

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU feeding the accumulator: single-cycle logic/arith ops,
// bit-serial MUL/DIV, registered result with a one-cycle write pulse.
module seq_alu
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input logic          clk,
  input logic          rst,
  seq_alu_if.slave     bus
);

  localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  is_div_q, is_div_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;
  logic                  flag_z_q, flag_z_d;
  logic                  flag_c_q, flag_c_d;

  logic [DATA_WIDTH:0]   sc_sum_c;
  logic [DATA_WIDTH:0]   sc_diff_c;
  logic [DATA_WIDTH-1:0] sc_result_c;
  logic                  sc_carry_c;
  logic [DATA_WIDTH-1:0] fin_result_c;
  logic                  fin_carry_c;
  logic                  md_load_c;

  logic                  md_step_done;
  logic [DATA_WIDTH-1:0] md_lo;
  logic [DATA_WIDTH-1:0] md_hi;
  logic                  md_div_zero;

  seq_muldiv #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_muldiv (
    .clk       (clk),
    .rst       (rst),
    .load      (md_load_c),
    .is_div    (bus.op == OP_DIV),
    .a         (bus.operand_a),
    .b         (bus.operand_b),
    .step_done (md_step_done),
    .res_lo    (md_lo),
    .res_hi    (md_hi),
    .div_zero  (md_div_zero)
  );

  // Single-cycle operations on the live inputs, used only on the accepting edge
  always_comb begin
    sc_sum_c    = {1'b0, bus.operand_a} + {1'b0, bus.operand_b};
    sc_diff_c   = {1'b0, bus.operand_a} - {1'b0, bus.operand_b};
    sc_result_c = '0;
    sc_carry_c  = 1'b0;
    case (bus.op)
      OP_ADD: begin
        sc_result_c = sc_sum_c[DATA_WIDTH-1:0];
        sc_carry_c  = sc_sum_c[DATA_WIDTH];
      end
      OP_SUB: begin
        sc_result_c = sc_diff_c[DATA_WIDTH-1:0];
        sc_carry_c  = sc_diff_c[DATA_WIDTH];
      end
      OP_AND:   sc_result_c = bus.operand_a & bus.operand_b;
      OP_OR:    sc_result_c = bus.operand_a | bus.operand_b;
      OP_XOR:   sc_result_c = bus.operand_a ^ bus.operand_b;
      OP_PASSB: sc_result_c = bus.operand_b;
      default: begin
        sc_result_c = '0;
        sc_carry_c  = 1'b0;
      end
    endcase
  end

  // Final MUL/DIV result; divide-by-zero is forced to all-ones with carry
  always_comb begin
    fin_result_c = md_lo;
    fin_carry_c  = |md_hi;
    if (is_div_q) begin
      fin_result_c = md_div_zero ? '1 : md_lo;
      fin_carry_c  = md_div_zero;
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      result_q <= result_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      flag_z_q <= flag_z_d;
      flag_c_q <= flag_c_d;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    result_d  = result_q;
    done_d    = 1'b0;
    busy_d    = busy_q;
    flag_z_d  = flag_z_q;
    flag_c_d  = flag_c_q;
    md_load_c = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (is_multi_cycle(bus.op)) begin
            state_d   = S_ITER;
            cnt_d     = '0;
            busy_d    = 1'b1;
            is_div_d  = (bus.op == OP_DIV);
            md_load_c = 1'b1;
          end else begin
            result_d = sc_result_c;
            flag_c_d = sc_carry_c;
            flag_z_d = (sc_result_c == '0);
            done_d   = 1'b1;
          end
        end
      end
      S_ITER: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        if (md_step_done) begin
          result_d = fin_result_c;
          flag_c_d = fin_carry_c;
          flag_z_d = (fin_result_c == '0);
          done_d   = 1'b1;
          busy_d   = 1'b0;
          cnt_d    = '0;
          state_d  = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign bus.result = result_q;
  assign bus.done   = done_q;
  assign bus.acc_we = done_q;
  assign bus.busy   = busy_q;
  assign bus.flag_z = flag_z_q;
  assign bus.flag_c = flag_c_q;

endmodule
